// File: rtl/sr_scan_ctrl.sv
// Round-robin ultrasonic ranger sequencer: trigger, wait for echo, time the echo-high
// width, enforce a quiet gap, then publish the count and a status code per sensor.
module sr_scan_ctrl #(
  parameter int N_SENS   = 3,
  parameter int CNT_W    = 16,
  parameter int TRIG_CYC = 12,
  parameter int START_TO = 5000,
  parameter int MAX_ECHO = 30000,
  parameter int GAP_CYC  = 60000,
  localparam int IDX_W   = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [N_SENS-1:0]         echo,
  output logic [N_SENS-1:0]         trig,
  output logic [N_SENS*CNT_W-1:0]   dist_bus,
  output logic                      meas_valid,
  output logic [IDX_W-1:0]          meas_idx,
  output logic [1:0]                meas_status,
  output logic                      busy
);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_NO_ECHO = 2'b01, ST_OVER = 2'b10} status_t;

  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_ECHO);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_SENS - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [N_SENS-1:0]  echo_m, echo_s, echo_d;
  logic               sel_s, sel_d;
  logic               pub;
  logic [CNT_W-1:0]   pub_val;
  status_t            pub_stat;

  // NOTE: reset is synchronous here, so it only appears inside the clocked branch
  // and the edge list holds the clock alone.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign sel_s = echo_s[idx];
  assign sel_d = echo_d[idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      dist_bus    <= '0;
      meas_valid  <= 1'b0;
      meas_idx    <= '0;
      meas_status <= ST_OK;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      meas_valid <= pub;
      if (pub) begin
        dist_bus[idx*CNT_W +: CNT_W] <= pub_val;
        meas_idx                     <= idx;
        meas_status                  <= pub_stat;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    pub      = 1'b0;
    pub_val  = '0;
    pub_stat = ST_OK;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = S_TRIG;
          cnt_nx   = '0;
        end
      end
      S_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_nx = S_WAIT_RISE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_WAIT_RISE: begin
        // A level already high on entry is stale; only a true 0->1 edge starts timing.
        if (sel_s && !sel_d) begin
          state_nx = S_MEASURE;
          cnt_nx   = CNT_ONE;
        end else if (cnt == START_LAST) begin
          pub      = 1'b1;
          pub_stat = ST_NO_ECHO;
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_MEASURE: begin
        if (!sel_s) begin
          pub      = 1'b1;
          pub_val  = cnt;
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else if (cnt == MAX_CNT) begin
          pub      = 1'b1;
          pub_val  = MAX_CNT;
          pub_stat = ST_OVER;
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          idx_nx   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          cnt_nx   = '0;
          state_nx = enable ? S_TRIG : S_IDLE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    trig = '0;
    if (state == S_TRIG) trig[idx] = 1'b1;
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_sr_scan_ctrl.sv
// Scenario bench for sr_scan_ctrl: expected publishes are queued as stimulus is driven
// and a negedge monitor pops and compares them whenever meas_valid fires.
module tb_sr_scan_ctrl;

  localparam int N_SENS   = 2;
  localparam int CNT_W    = 16;
  localparam int TRIG_CYC = 4;
  localparam int START_TO = 20;
  localparam int MAX_ECHO = 50;
  localparam int GAP_CYC  = 10;

  logic                    clk_in = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic [N_SENS-1:0]       echo;
  logic [N_SENS-1:0]       trig;
  logic [N_SENS*CNT_W-1:0] dist_bus;
  logic                    meas_valid;
  logic [0:0]              meas_idx;
  logic [1:0]              meas_status;
  logic                    busy;

  typedef struct packed {
    logic [0:0]       idx;
    logic [CNT_W-1:0] val;
    logic [1:0]       st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_valid = 1'b0;

  sr_scan_ctrl #(
    .N_SENS(N_SENS), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC),
    .START_TO(START_TO), .MAX_ECHO(MAX_ECHO), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
    .dist_bus(dist_bus), .meas_valid(meas_valid), .meas_idx(meas_idx),
    .meas_status(meas_status), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (meas_valid) begin
      exp_t       e;
      logic [CNT_W-1:0] slot;
      n_checks++;
      slot = dist_bus[meas_idx*CNT_W +: CNT_W];
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_publish: idx=%0d val=%0d st=%b, none expected",
                 meas_idx, slot, meas_status);
      end else begin
        e = exp_q.pop_front();
        if (meas_idx !== e.idx || slot !== e.val || meas_status !== e.st) begin
          n_fail++;
          $display("FAIL publish: got idx=%0d val=%0d st=%b, want idx=%0d val=%0d st=%b",
                   meas_idx, slot, meas_status, e.idx, e.val, e.st);
        end
      end
      n_checks++;
      if (prev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_width: meas_valid high on consecutive cycles, want one-cycle pulse");
      end
    end
    prev_valid = meas_valid;
  end

  function automatic bit cond_met(input int which);
    case (which)
      0:       return trig[0] === 1'b1;
      1:       return trig[1] === 1'b1;
      2:       return trig === '0;
      3:       return meas_valid === 1'b1;
      4:       return busy === 1'b0;
      default: return trig !== '0;
    endcase
  endfunction

  task automatic wait_for(input string what, input int which, input int bound, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (cond_met(which)) break;
      if (cyc >= bound) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: condition not seen in %0d cycles, want it within bound",
                 what, bound);
        break;
      end
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    enable = 1'b0;
    echo   = '0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if (trig !== '0 || dist_bus !== '0 || meas_valid !== 1'b0 || meas_idx !== 1'b0 ||
        meas_status !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: trig=%b dist=%h valid=%b idx=%0d st=%b busy=%b, want all 0",
               trig, dist_bus, meas_valid, meas_idx, meas_status, busy);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    expect_int("idle_without_enable_busy", int'(busy), 0);
  endtask

  task automatic test_nominal;
    int c;
    enable = 1'b1;
    wait_for("trig0_rise", 0, 20, c);
    wait_for("trig0_fall", 2, 20, c);
    expect_int("nominal_trig_width", c, TRIG_CYC);
    repeat (3) @(negedge clk_in);
    exp_q.push_back('{idx: 1'b0, val: CNT_W'(17), st: 2'b00});
    echo[0] = 1'b1;
    repeat (17) @(negedge clk_in);
    echo[0] = 1'b0;
    wait_for("nominal_valid", 3, 20, c);
    wait_for("trig1_rise", 1, 30, c);
    expect_int("gap_to_trig1", c, GAP_CYC);
  endtask

  task automatic test_no_echo;
    int c;
    exp_q.push_back('{idx: 1'b1, val: '0, st: 2'b01});
    wait_for("trig1_fall", 2, 20, c);
    wait_for("noecho_valid", 3, 40, c);
    expect_int("noecho_latency", c, START_TO);
    expect_int("noecho_slot0_held", int'(dist_bus[0 +: CNT_W]), 17);
  endtask

  task automatic test_overrange;
    int c, el;
    wait_for("trig0_rise_ovr", 0, 30, c);
    wait_for("trig0_fall_ovr", 2, 20, c);
    exp_q.push_back('{idx: 1'b0, val: CNT_W'(MAX_ECHO), st: 2'b10});
    echo[0] = 1'b1;
    el = 0;
    wait_for("ovr_valid", 3, 79, c);
    el += c;
    // 2 synchronizer stages, then MAX_ECHO+1 high samples before saturation is declared.
    expect_int("ovr_latency", el, MAX_ECHO + 3);
    exp_q.push_back('{idx: 1'b1, val: '0, st: 2'b01});
    wait_for("trig1_rise_ovr", 1, 20, c);
    el += c;
    expect_int("ovr_next_trig_not_delayed", c, GAP_CYC);
    if (el < 80) repeat (80 - el) @(negedge clk_in);
    echo[0] = 1'b0;
  endtask

  task automatic test_stale_crosstalk;
    int c;
    wait_for("trig0_rise_stale", 0, 60, c);
    echo[0] = 1'b1;
    wait_for("trig0_fall_stale", 2, 20, c);
    exp_q.push_back('{idx: 1'b0, val: '0, st: 2'b01});
    c = 0;
    forever begin
      @(negedge clk_in);
      c++;
      if (meas_valid) break;
      if (c == 8) echo[0] = 1'b0;
      echo[1] = (c < 16) ? ~echo[1] : 1'b0;
      if (c >= 30) break;
    end
    echo = '0;
    expect_int("stale_noecho_latency", c, START_TO);
  endtask

  task automatic test_enable_drop;
    int  c;
    bit  saw_trig;
    wait_for("trig1_rise_en", 1, 40, c);
    wait_for("trig1_fall_en", 2, 20, c);
    repeat (2) @(negedge clk_in);
    exp_q.push_back('{idx: 1'b1, val: CNT_W'(7), st: 2'b00});
    echo[1] = 1'b1;
    repeat (4) @(negedge clk_in);
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    echo[1] = 1'b0;
    wait_for("en_valid", 3, 20, c);
    wait_for("en_idle", 4, 30, c);
    expect_int("enable_drop_gap_then_idle", c, GAP_CYC);
    saw_trig = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      if (trig !== '0 || busy !== 1'b0) saw_trig = 1'b1;
    end
    expect_int("idle_stays_quiet", int'(saw_trig), 0);
    enable = 1'b1;
    wait_for("reenable_trig", 5, 10, c);
    expect_int("reenable_latency", c, 1);
    expect_int("reenable_wraps_to_trig0", int'(trig), 1);
  endtask

  task automatic test_reset_mid_trig;
    int c;
    exp_q.push_back('{idx: 1'b0, val: '0, st: 2'b01});
    wait_for("trig0_fall_rst", 2, 20, c);
    wait_for("rst_prev_valid", 3, 40, c);
    wait_for("trig1_rise_rst", 1, 20, c);
    @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    n_checks++;
    if (trig !== '0 || dist_bus !== '0 || busy !== 1'b0 || meas_valid !== 1'b0 ||
        meas_idx !== 1'b0 || meas_status !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_trig: trig=%b dist=%h busy=%b valid=%b idx=%0d st=%b, want all 0",
               trig, dist_bus, busy, meas_valid, meas_idx, meas_status);
    end
    wait_for("post_reset_trig", 5, 10, c);
    expect_int("post_reset_idx0_trig", int'(trig), 1);
    repeat (6) @(negedge clk_in);
    expect_int("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_echo();
    test_overrange();
    test_stale_crosstalk();
    test_enable_drop();
    test_reset_mid_trig();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
